// File: rtl/dispatch_issue_queue_if.sv
// Dispatch-to-scheduler write bus and issue handshake.
// Master drives dispatch/wakeup/accept, slave is the queue.
interface dispatch_issue_queue_if #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int PTR_W          = 4,
  parameter int TAG_W          = 6,
  parameter int PAYLOAD_W      = 64,
  parameter int WAKEUP_WIDTH   = 2
);
  logic                                flush;
  logic [DISPATCH_WIDTH-1:0]           write;
  logic [DISPATCH_WIDTH*PTR_W-1:0]     writePtr;
  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] writeData;
  logic [DISPATCH_WIDTH-1:0]           srcValidA;
  logic [DISPATCH_WIDTH-1:0]           srcValidB;
  logic [DISPATCH_WIDTH*TAG_W-1:0]     srcTagA;
  logic [DISPATCH_WIDTH*TAG_W-1:0]     srcTagB;
  logic [WAKEUP_WIDTH-1:0]             wakeupValid;
  logic [WAKEUP_WIDTH*TAG_W-1:0]       wakeupTag;
  logic                                issueValid;
  logic                                issueReady;
  logic [PTR_W-1:0]                    issuePtr;
  logic [PAYLOAD_W-1:0]                issueData;
  logic [PTR_W:0]                      validCount;
  logic                                errOverwrite;

  modport master (
    output flush, write, writePtr, writeData,
    output srcValidA, srcValidB, srcTagA, srcTagB,
    output wakeupValid, wakeupTag, issueReady,
    input  issueValid, issuePtr, issueData,
    input  validCount, errOverwrite
  );

  modport slave (
    input  flush, write, writePtr, writeData,
    input  srcValidA, srcValidB, srcTagA, srcTagB,
    input  wakeupValid, wakeupTag, issueReady,
    output issueValid, issuePtr, issueData,
    output validCount, errOverwrite
  );
endinterface

// File: rtl/dispatch_issue_queue.sv
// Issue queue: dispatch writes at rename-allocated slots, tag
// wakeup, lowest-index ready select, valid/ready issue.
module dispatch_issue_queue #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ENTRY_NUM      = 16,
  parameter int PTR_W          = 4,
  parameter int TAG_W          = 6,
  parameter int PAYLOAD_W      = 64,
  parameter int WAKEUP_WIDTH   = 2
) (
  input logic clk,
  input logic rstN,
  dispatch_issue_queue_if.slave io
);
  localparam int N = ENTRY_NUM;
  localparam int DW = DISPATCH_WIDTH;

  logic [N-1:0]           valid_q, valid_d;
  logic [N-1:0]           rdy_a_q, rdy_a_d;
  logic [N-1:0]           rdy_b_q, rdy_b_d;
  logic [TAG_W-1:0]       tag_a_q [N];
  logic [TAG_W-1:0]       tag_a_d [N];
  logic [TAG_W-1:0]       tag_b_q [N];
  logic [TAG_W-1:0]       tag_b_d [N];
  logic [PAYLOAD_W-1:0]   pay_q [N];
  logic [PAYLOAD_W-1:0]   pay_d [N];
  logic [PTR_W:0]         cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   sel_found;
  logic [PTR_W-1:0]       sel_ptr;
  logic                   fire;

  logic [PTR_W-1:0]       wr_ptr   [DW];
  logic [TAG_W-1:0]       wr_tag_a [DW];
  logic [TAG_W-1:0]       wr_tag_b [DW];
  logic [PAYLOAD_W-1:0]   wr_pay   [DW];
  logic [DW-1:0]          wr_rdy_a, wr_rdy_b;

  function automatic logic woken(
    input logic [TAG_W-1:0]              t,
    input logic [WAKEUP_WIDTH-1:0]       wv,
    input logic [WAKEUP_WIDTH*TAG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKEUP_WIDTH; k++)
      if (wv[k] && wt[k*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  for (genvar g = 0; g < DW; g++) begin : g_lane
    assign wr_ptr[g]   = io.writePtr[g*PTR_W +: PTR_W];
    assign wr_tag_a[g] = io.srcTagA[g*TAG_W +: TAG_W];
    assign wr_tag_b[g] = io.srcTagB[g*TAG_W +: TAG_W];
    assign wr_pay[g]   = io.writeData[g*PAYLOAD_W +: PAYLOAD_W];
    assign wr_rdy_a[g] = !io.srcValidA[g] ||
      woken(wr_tag_a[g], io.wakeupValid, io.wakeupTag);
    assign wr_rdy_b[g] = !io.srcValidB[g] ||
      woken(wr_tag_b[g], io.wakeupValid, io.wakeupTag);
  end

  // pick the lowest-index slot with both operands ready
  always_comb begin
    sel_found = 1'b0;
    sel_ptr   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_q[i] && rdy_a_q[i] && rdy_b_q[i]) begin
        sel_found = 1'b1;
        sel_ptr   = PTR_W'(i);
      end
    end
  end

  assign fire            = sel_found && io.issueReady;
  assign io.issueValid   = sel_found;
  assign io.issuePtr     = sel_ptr;
  assign io.issueData    = sel_found ? pay_q[sel_ptr] : '0;
  assign io.validCount   = cnt_q;
  assign io.errOverwrite = err_q;

  // wakeup, issue free, dispatch writes (higher lane last), flush
  always_comb begin
    valid_d = valid_q;
    rdy_a_d = rdy_a_q;
    rdy_b_d = rdy_b_q;
    tag_a_d = tag_a_q;
    tag_b_d = tag_b_q;
    pay_d   = pay_q;
    err_d   = err_q;
    for (int i = 0; i < N; i++) begin
      if (valid_q[i] &&
          woken(tag_a_q[i], io.wakeupValid, io.wakeupTag))
        rdy_a_d[i] = 1'b1;
      if (valid_q[i] &&
          woken(tag_b_q[i], io.wakeupValid, io.wakeupTag))
        rdy_b_d[i] = 1'b1;
    end
    if (fire) valid_d[sel_ptr] = 1'b0;
    for (int l = 0; l < DW; l++) begin
      if (io.write[l]) begin
        valid_d[wr_ptr[l]] = 1'b1;
        rdy_a_d[wr_ptr[l]] = wr_rdy_a[l];
        rdy_b_d[wr_ptr[l]] = wr_rdy_b[l];
        tag_a_d[wr_ptr[l]] = wr_tag_a[l];
        tag_b_d[wr_ptr[l]] = wr_tag_b[l];
        pay_d[wr_ptr[l]]   = wr_pay[l];
        if (valid_q[wr_ptr[l]] &&
            !(fire && sel_ptr == wr_ptr[l]))
          err_d = 1'b1;
        for (int k = 0; k < l; k++)
          if (io.write[k] && wr_ptr[k] == wr_ptr[l])
            err_d = 1'b1;
      end
    end
    if (io.flush) begin
      valid_d = '0;
      err_d   = err_q;
    end
    cnt_d = '0;
    for (int i = 0; i < N; i++)
      cnt_d = cnt_d + (PTR_W + 1)'(valid_d[i]);
  end

  // control state: valid/ready bits, count, sticky error
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= '0;
      rdy_a_q <= '0;
      rdy_b_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rdy_a_q <= rdy_a_d;
      rdy_b_q <= rdy_b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // tags and payload carry no reset
  always_ff @(posedge clk) begin
    tag_a_q <= tag_a_d;
    tag_b_q <= tag_b_d;
    pay_q   <= pay_d;
  end
endmodule

// File: tb/tb_dispatch_issue_queue.sv
// Directed bench for dispatch_issue_queue.
// Inputs change #1 after posedge, outputs checked there.
module tb_dispatch_issue_queue;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dispatch_issue_queue_if #(
    .DISPATCH_WIDTH(2), .PTR_W(4), .TAG_W(6),
    .PAYLOAD_W(64), .WAKEUP_WIDTH(2)
  ) dif ();

  dispatch_issue_queue #(
    .DISPATCH_WIDTH(2), .ENTRY_NUM(16), .PTR_W(4),
    .TAG_W(6), .PAYLOAD_W(64), .WAKEUP_WIDTH(2)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .io(dif)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dif.flush       = 1'b0;
    dif.write       = '0;
    dif.writePtr    = '0;
    dif.writeData   = '0;
    dif.srcValidA   = '0;
    dif.srcValidB   = '0;
    dif.srcTagA     = '0;
    dif.srcTagB     = '0;
    dif.wakeupValid = '0;
    dif.wakeupTag   = '0;
  endtask

  task automatic wr(input int l, input logic [3:0] p,
                    input logic [63:0] d,
                    input logic va, input logic [5:0] ta,
                    input logic vb, input logic [5:0] tb);
    dif.write[l]             = 1'b1;
    dif.writePtr[l*4 +: 4]   = p;
    dif.writeData[l*64 +: 64] = d;
    dif.srcValidA[l]         = va;
    dif.srcTagA[l*6 +: 6]    = ta;
    dif.srcValidB[l]         = vb;
    dif.srcTagB[l*6 +: 6]    = tb;
  endtask

  task automatic wk(input int l, input logic [5:0] t);
    dif.wakeupValid[l]      = 1'b1;
    dif.wakeupTag[l*6 +: 6] = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    dif.issueReady = 1'b0;
    step();
    step();
    rstN = 1'b1;
    step();

    // five ready slots, then asynchronous reset
    wr(0, 4'd0, 64'h10, 0, 0, 0, 0);
    wr(1, 4'd1, 64'h11, 0, 0, 0, 0);
    step(); clr();
    wr(0, 4'd2, 64'h12, 0, 0, 0, 0);
    wr(1, 4'd3, 64'h13, 0, 0, 0, 0);
    step(); clr();
    wr(0, 4'd4, 64'h14, 0, 0, 0, 0);
    step(); clr();
    chk("pre_rst_cnt", 64'(dif.validCount), 64'd5);
    chk("pre_rst_iv", 64'(dif.issueValid), 64'd1);
    #2 rstN = 1'b0;
    #1;
    chk("rst_iv", 64'(dif.issueValid), 64'd0);
    chk("rst_ptr", 64'(dif.issuePtr), 64'd0);
    chk("rst_data", dif.issueData, 64'd0);
    chk("rst_cnt", 64'(dif.validCount), 64'd0);
    chk("rst_err", 64'(dif.errOverwrite), 64'd0);
    rstN = 1'b1;
    step();
    chk("post_rst_iv", 64'(dif.issueValid), 64'd0);
    chk("post_rst_cnt", 64'(dif.validCount), 64'd0);

    // ready at dispatch
    wr(0, 4'd3, 64'hAA, 0, 0, 0, 0);
    step(); clr();
    chk("rad_iv", 64'(dif.issueValid), 64'd1);
    chk("rad_ptr", 64'(dif.issuePtr), 64'd3);
    chk("rad_data", dif.issueData, 64'hAA);
    chk("rad_cnt", 64'(dif.validCount), 64'd1);
    dif.issueReady = 1'b1;
    step();
    dif.issueReady = 1'b0;
    chk("rad_free_cnt", 64'(dif.validCount), 64'd0);
    chk("rad_free_iv", 64'(dif.issueValid), 64'd0);

    // wakeup after dispatch, via broadcast lane 1
    wr(0, 4'd5, 64'h55, 1, 6'd17, 0, 0);
    step(); clr();
    chk("wk_wait_iv", 64'(dif.issueValid), 64'd0);
    chk("wk_wait_cnt", 64'(dif.validCount), 64'd1);
    step();
    chk("wk_wait2_iv", 64'(dif.issueValid), 64'd0);
    wk(1, 6'd17);
    step(); clr();
    chk("wk_iv", 64'(dif.issueValid), 64'd1);
    chk("wk_ptr", 64'(dif.issuePtr), 64'd5);
    chk("wk_data", dif.issueData, 64'h55);
    dif.issueReady = 1'b1;
    step();
    dif.issueReady = 1'b0;
    chk("wk_free_cnt", 64'(dif.validCount), 64'd0);

    // same-cycle bypass on both operands
    wr(0, 4'd6, 64'h66, 1, 6'd17, 1, 6'd22);
    wk(0, 6'd17);
    wk(1, 6'd22);
    step(); clr();
    chk("byp_iv", 64'(dif.issueValid), 64'd1);
    chk("byp_ptr", 64'(dif.issuePtr), 64'd6);
    dif.issueReady = 1'b1;
    step();
    dif.issueReady = 1'b0;

    // exact tag match: 49 differs from 17 only in bit 5
    wr(1, 4'd8, 64'h88, 1, 6'd17, 0, 0);
    step(); clr();
    wk(0, 6'd49);
    step(); clr();
    chk("nomatch_iv", 64'(dif.issueValid), 64'd0);
    wk(0, 6'd17);
    step(); clr();
    chk("match_iv", 64'(dif.issueValid), 64'd1);
    chk("match_ptr", 64'(dif.issuePtr), 64'd8);
    dif.issueReady = 1'b1;
    step();
    dif.issueReady = 1'b0;
    chk("match_free_cnt", 64'(dif.validCount), 64'd0);

    // priority and backpressure
    wr(0, 4'd9, 64'h99, 0, 0, 0, 0);
    wr(1, 4'd2, 64'h22, 0, 0, 0, 0);
    step(); clr();
    for (int c = 0; c < 3; c++) begin
      chk("bp_ptr", 64'(dif.issuePtr), 64'd2);
      chk("bp_data", dif.issueData, 64'h22);
      step();
    end
    dif.issueReady = 1'b1;
    step();
    dif.issueReady = 1'b0;
    chk("pri_ptr", 64'(dif.issuePtr), 64'd9);
    chk("pri_data", dif.issueData, 64'h99);
    chk("pri_cnt", 64'(dif.validCount), 64'd1);
    dif.issueReady = 1'b1;
    step();
    dif.issueReady = 1'b0;
    chk("pri_free_cnt", 64'(dif.validCount), 64'd0);

    // fill all slots
    for (int k = 0; k < 8; k++) begin
      wr(0, 4'(2*k), 64'h100 + 64'(2*k), 0, 0, 0, 0);
      wr(1, 4'(2*k+1), 64'h101 + 64'(2*k), 0, 0, 0, 0);
      step(); clr();
    end
    chk("full_cnt", 64'(dif.validCount), 64'h10);
    chk("full_ptr", 64'(dif.issuePtr), 64'd0);
    chk("full_data", dif.issueData, 64'h100);
    dif.issueReady = 1'b1;
    wr(0, 4'd0, 64'hBEEF, 0, 0, 0, 0);
    step(); clr();
    dif.issueReady = 1'b0;
    chk("swap_cnt", 64'(dif.validCount), 64'h10);
    chk("swap_err", 64'(dif.errOverwrite), 64'd0);
    chk("swap_data", dif.issueData, 64'hBEEF);
    dif.flush = 1'b1;
    step(); clr();
    chk("flush1_cnt", 64'(dif.validCount), 64'd0);

    // duplicate lane pointers, then flush with write/accept
    wr(0, 4'd7, 64'h111, 0, 0, 0, 0);
    wr(1, 4'd7, 64'h222, 0, 0, 0, 0);
    step(); clr();
    chk("dup_err", 64'(dif.errOverwrite), 64'd1);
    chk("dup_ptr", 64'(dif.issuePtr), 64'd7);
    chk("dup_data", dif.issueData, 64'h222);
    chk("dup_cnt", 64'(dif.validCount), 64'd1);
    dif.flush = 1'b1;
    dif.issueReady = 1'b1;
    wr(0, 4'd1, 64'h333, 0, 0, 0, 0);
    step(); clr();
    dif.issueReady = 1'b0;
    chk("fl_cnt", 64'(dif.validCount), 64'd0);
    chk("fl_iv", 64'(dif.issueValid), 64'd0);
    chk("fl_err", 64'(dif.errOverwrite), 64'd1);
    step();
    chk("fl_cnt2", 64'(dif.validCount), 64'd0);

    // overwrite of an occupied slot under backpressure
    rstN = 1'b0;
    #1 rstN = 1'b1;
    step();
    chk("ow_err0", 64'(dif.errOverwrite), 64'd0);
    wr(0, 4'd4, 64'h44, 0, 0, 0, 0);
    step(); clr();
    chk("ow_err1", 64'(dif.errOverwrite), 64'd0);
    wr(1, 4'd4, 64'h45, 0, 0, 0, 0);
    step(); clr();
    chk("ow_err2", 64'(dif.errOverwrite), 64'd1);
    chk("ow_data", dif.issueData, 64'h45);
    chk("ow_cnt", 64'(dif.validCount), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
